controle_execucao: RTL

Run/step control unit placed directly upstream of the processor frequency divider. It debounces the board run switch and step pushbutton, runs a small execution FSM, and drives the divider's `halt` and `congela` inputs. The processor can then free-run, execute exactly one divided-clock pulse per button press, or stop permanently on a CPU halt instruction.

---
 rtl/controle_pkg.sv | 13 +
 rtl/controle_execucao_if.sv | 24 ++
 rtl/debounce_entrada.sv | 44 ++++
 rtl/controle_execucao.sv | 121 ++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared definitions for the run/step execution controller: state codes and counter width.
package controle_pkg;

    typedef enum logic [1:0] {
        PARADO     = 2'd0,
        EXECUTANDO = 2'd1,
        PASSO      = 2'd2,
        FIM        = 2'd3
    } estado_t;

    localparam int CICLOS_WIDTH = 32;

endpackage

// File: rtl/controle_execucao_if.sv
// Board inputs and divider-side signals of the execution controller, bundled as one interface.
interface controle_execucao_if;
    import controle_pkg::*;

    logic                    sw_run;
    logic                    btn_step;
    logic                    halt_cpu;
    logic                    new_clock;
    logic                    halt;
    logic                    congela;
    logic [1:0]              estado;
    logic [CICLOS_WIDTH-1:0] ciclos;

    modport master (
        input  sw_run, btn_step, halt_cpu, new_clock,
        output halt, congela, estado, ciclos
    );

    modport slave (
        output sw_run, btn_step, halt_cpu, new_clock,
        input  halt, congela, estado, ciclos
    );

endinterface

// File: rtl/debounce_entrada.sv
// Two-flop synchronizer followed by a stability counter; the level follows the input only
// after DEBOUNCE_CYCLES consecutive cycles of the new synchronized value.
module debounce_entrada #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock_fpga,
    input  logic reset_n,
    input  logic entrada,
    output logic nivel
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          nivel_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock_fpga) begin
        if (!reset_n) begin
            sync1_reg <= RESET_VALUE;
            sync2_reg <= RESET_VALUE;
            nivel_reg <= RESET_VALUE;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= entrada;
            sync2_reg <= sync1_reg;
            // Any sample matching the current level restarts the stability run.
            if (sync2_reg == nivel_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                nivel_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign nivel = nivel_reg;

endmodule

// File: rtl/controle_execucao.sv
// Run/step controller driving the frequency divider's halt/congela inputs.
// Optional cycle counter on ciclos is enabled by defining CONTADOR_CICLOS_EN.
module controle_execucao
    import controle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clock_fpga,
    input  logic               reset_n,
    controle_execucao_if.master bus
);

    // Bit 0 = run switch (rests at 0), bit 1 = step button (active-low, rests at 1).
    localparam logic [1:0] NIVEL_REPOUSO = 2'b10;

    logic [1:0] raw_in;
    logic [1:0] nivel;
    logic       run_nivel;
    logic       btn_nivel;
    logic       step_req;

    estado_t    estado_reg;
    logic       halt_reg;
    logic       congela_reg;
    logic       btn_prev_reg;

    assign raw_in = {bus.btn_step, bus.sw_run};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            debounce_entrada #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VALUE     (NIVEL_REPOUSO[gi])
            ) u_debounce (
                .clock_fpga (clock_fpga),
                .reset_n    (reset_n),
                .entrada    (raw_in[gi]),
                .nivel      (nivel[gi])
            );
        end
    endgenerate

    assign run_nivel = nivel[0];
    assign btn_nivel = nivel[1];
    assign step_req  = btn_prev_reg & ~btn_nivel;

    always_ff @(posedge clock_fpga) begin
        if (!reset_n) begin
            estado_reg   <= PARADO;
            halt_reg     <= 1'b1;
            congela_reg  <= 1'b0;
            btn_prev_reg <= 1'b1;
        end else begin
            btn_prev_reg <= btn_nivel;
            congela_reg  <= 1'b0;
            if (bus.halt_cpu) begin
                estado_reg <= FIM;
                halt_reg   <= 1'b1;
            end else begin
                case (estado_reg)
                    PARADO: begin
                        if (run_nivel) begin
                            estado_reg <= EXECUTANDO;
                            halt_reg   <= 1'b0;
                        end else if (step_req) begin
                            estado_reg  <= PASSO;
                            halt_reg    <= 1'b0;
                            congela_reg <= 1'b1;
                        end else begin
                            halt_reg <= 1'b1;
                        end
                    end
                    EXECUTANDO: begin
                        if (!run_nivel) begin
                            estado_reg <= PARADO;
                            halt_reg   <= 1'b1;
                        end else begin
                            halt_reg <= 1'b0;
                        end
                    end
                    PASSO: begin
                        // The entry cycle is the divider clear, so its pulse cannot end the step.
                        if (bus.new_clock && !congela_reg) begin
                            estado_reg <= PARADO;
                            halt_reg   <= 1'b1;
                        end else begin
                            halt_reg <= 1'b0;
                        end
                    end
                    default: begin
                        estado_reg <= FIM;
                        halt_reg   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.halt    = halt_reg;
    assign bus.congela = congela_reg;
    assign bus.estado  = estado_reg;

`ifdef CONTADOR_CICLOS_EN
    logic [CICLOS_WIDTH-1:0] ciclos_reg;

    // Pulses arriving during the divider clear are not delivered to the processor.
    always_ff @(posedge clock_fpga) begin
        if (!reset_n) begin
            ciclos_reg <= '0;
        end else if (bus.new_clock && !halt_reg && !congela_reg) begin
            ciclos_reg <= ciclos_reg + 1'b1;
        end
    end

    assign bus.ciclos = ciclos_reg;
`else
    assign bus.ciclos = '0;
`endif

endmodule
